// File: rtl/mod_op_sched.sv
// mod_op_sched: round-robin scheduler sharing one add/sub/mul/div mod P datapath between two requesters; ports clk, rst_n, req{0,1}_{valid,ready,op,a,b}, rsp_{valid,ready,id,data,err}; divider built only when MOD_OP_SCHED_DIV_EN is defined (P must be prime)
module mod_op_sched #(
  parameter int DATAWIDTH = 5,
  parameter int P = 23,
  parameter int MUL_CYCLES = 4,
  parameter int DIV_CYCLES = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 req0_valid,
  output logic                 req0_ready,
  input  logic [1:0]           req0_op,
  input  logic [DATAWIDTH-1:0] req0_a,
  input  logic [DATAWIDTH-1:0] req0_b,
  input  logic                 req1_valid,
  output logic                 req1_ready,
  input  logic [1:0]           req1_op,
  input  logic [DATAWIDTH-1:0] req1_a,
  input  logic [DATAWIDTH-1:0] req1_b,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic                 rsp_id,
  output logic [DATAWIDTH-1:0] rsp_data,
  output logic                 rsp_err
);
  localparam int MAXL = MUL_CYCLES > DIV_CYCLES ? MUL_CYCLES : DIV_CYCLES;
  localparam int CW = $clog2(MAXL) + 1;
  localparam logic [DATAWIDTH:0] PW = (DATAWIDTH + 1)'(P);
  localparam logic [2*DATAWIDTH-1:0] PM = (2 * DATAWIDTH)'(P);
  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
  state_t state;
  logic rr, id_r, err_r;
  logic [1:0] op_r;
  logic [DATAWIDTH-1:0] a_r, b_r;
  logic [CW-1:0] cnt;
  logic grant0, grant1, sel_err;
  logic [1:0] sel_op;
  logic [DATAWIDTH-1:0] sel_a, sel_b;
  logic [CW-1:0] sel_lat;
  logic [DATAWIDTH-1:0] add_res, sub_res, mul_res, div_res, res;
  function automatic logic [DATAWIDTH-1:0] mulmod(input logic [DATAWIDTH-1:0] x, input logic [DATAWIDTH-1:0] y);
    logic [2*DATAWIDTH-1:0] t;
    t = ({{DATAWIDTH{1'b0}}, x} * {{DATAWIDTH{1'b0}}, y}) % PM;
    return t[DATAWIDTH-1:0];
  endfunction
  function automatic logic [DATAWIDTH-1:0] reduce(input logic [DATAWIDTH:0] s);
    logic [DATAWIDTH:0] t;
    t = s >= PW ? s - PW : s;
    return t[DATAWIDTH-1:0];
  endfunction
  assign grant0 = req0_valid & (~req1_valid | ~rr);
  assign grant1 = req1_valid & (~req0_valid | rr);
  assign req0_ready = (state == IDLE) & grant0;
  assign req1_ready = (state == IDLE) & grant1;
  assign sel_op = grant1 ? req1_op : req0_op;
  assign sel_a = grant1 ? req1_a : req0_a;
  assign sel_b = grant1 ? req1_b : req0_b;
`ifdef MOD_OP_SCHED_DIV_EN
  localparam logic [DATAWIDTH-1:0] E = DATAWIDTH'(P - 2);
  logic [DATAWIDTH-1:0] inv, base;
  assign sel_err = ({1'b0, sel_a} >= PW) | ({1'b0, sel_b} >= PW) | ((sel_op == 2'b11) & (sel_b == '0));
  always_comb begin
    inv = DATAWIDTH'(1);
    base = b_r;
    for (int i = 0; i < DATAWIDTH; i++) begin
      inv = E[i] ? mulmod(inv, base) : inv;
      base = mulmod(base, base);
    end
  end
  assign div_res = mulmod(a_r, inv);
`else
  assign sel_err = ({1'b0, sel_a} >= PW) | ({1'b0, sel_b} >= PW) | (sel_op == 2'b11);
  assign div_res = '0;
`endif
  assign sel_lat = (sel_err | ~sel_op[1]) ? '0 : sel_op[0] ? CW'(DIV_CYCLES - 1) : CW'(MUL_CYCLES - 1);
  assign add_res = reduce({1'b0, a_r} + {1'b0, b_r});
  assign sub_res = reduce({1'b0, a_r} + PW - {1'b0, b_r});
  assign mul_res = mulmod(a_r, b_r);
  assign res = err_r ? '0 : op_r[1] ? (op_r[0] ? div_res : mul_res) : (op_r[0] ? sub_res : add_res);
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      rr <= 1'b0;
      cnt <= '0;
      op_r <= '0;
      a_r <= '0;
      b_r <= '0;
      id_r <= 1'b0;
      err_r <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_id <= 1'b0;
      rsp_data <= '0;
      rsp_err <= 1'b0;
    end else begin
      case (state)
        IDLE: if (grant0 | grant1) begin
          op_r <= sel_op;
          a_r <= sel_a;
          b_r <= sel_b;
          id_r <= grant1;
          err_r <= sel_err;
          rr <= grant0;
          cnt <= sel_lat;
          state <= BUSY;
        end
        BUSY: if (cnt == '0) begin
          rsp_data <= res;
          rsp_err <= err_r;
          rsp_id <= id_r;
          rsp_valid <= 1'b1;
          state <= DONE;
        end else cnt <= cnt - CW'(1);
        DONE: if (rsp_ready) begin
          rsp_valid <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_mod_op_sched.sv
// tb_mod_op_sched: directed vector bench for mod_op_sched with P=23, DATAWIDTH=5, tracks MOD_OP_SCHED_DIV_EN
module tb_mod_op_sched;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic req0_valid = 1'b0, req1_valid = 1'b0, rsp_ready = 1'b0;
  logic req0_ready, req1_ready, rsp_valid, rsp_id, rsp_err;
  logic [1:0] req0_op = '0, req1_op = '0;
  logic [4:0] req0_a = '0, req0_b = '0, req1_a = '0, req1_b = '0, rsp_data;
  int checks = 0;
  int failures = 0;
  typedef struct {
    string name;
    logic id;
    logic [1:0] op;
    logic [4:0] a;
    logic [4:0] b;
    logic [4:0] data;
    logic err;
    int lat;
  } vec_t;
  vec_t v[12];
  mod_op_sched #(.DATAWIDTH(5), .P(23), .MUL_CYCLES(4), .DIV_CYCLES(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_op(req0_op), .req0_a(req0_a), .req0_b(req0_b),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_op(req1_op), .req1_a(req1_a), .req1_b(req1_b),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_data(rsp_data), .rsp_err(rsp_err)
  );
  always #5 clk = ~clk;
  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end
  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d expected=%0d", name, got, exp);
    end
  endtask
  task automatic drive(input logic id, input logic [1:0] op, input logic [4:0] a, input logic [4:0] b);
    if (id) begin
      req1_valid = 1'b1; req1_op = op; req1_a = a; req1_b = b;
    end else begin
      req0_valid = 1'b1; req0_op = op; req0_a = a; req0_b = b;
    end
  endtask
  task automatic run_op(input logic id, input logic [1:0] op, input logic [4:0] a, input logic [4:0] b,
                        output logic rdy, output int lat, output logic [4:0] d, output logic e,
                        output logic ri, output logic after);
    drive(id, op, a, b);
    #1 rdy = id ? req1_ready : req0_ready;
    @(posedge clk);
    @(negedge clk);
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    lat = 0;
    while (!rsp_valid && lat < 40) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
    end
    d = rsp_data;
    e = rsp_err;
    ri = rsp_id;
    rsp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rsp_ready = 1'b0;
    after = rsp_valid;
  endtask
  initial begin
    logic rdy, e, ri, after;
    logic [4:0] d, d0;
    logic e0, i0, stable, rdy_low;
    int lat;
    int g[$];
    int t[$];
    logic both;
    v[0]  = '{"add20_5",   1'b0, 2'b00, 5'd20, 5'd5,  5'd2,  1'b0, 1};
    v[1]  = '{"sub3_7",    1'b0, 2'b01, 5'd3,  5'd7,  5'd19, 1'b0, 1};
    v[2]  = '{"mul7_5",    1'b1, 2'b10, 5'd7,  5'd5,  5'd12, 1'b0, 4};
`ifdef MOD_OP_SCHED_DIV_EN
    v[3]  = '{"div1_5",    1'b0, 2'b11, 5'd1,  5'd5,  5'd14, 1'b0, 8};
    v[7]  = '{"div6_4",    1'b1, 2'b11, 5'd6,  5'd4,  5'd13, 1'b0, 8};
`else
    v[3]  = '{"div1_5",    1'b0, 2'b11, 5'd1,  5'd5,  5'd0,  1'b1, 1};
    v[7]  = '{"div6_4",    1'b1, 2'b11, 5'd6,  5'd4,  5'd0,  1'b1, 1};
`endif
    v[4]  = '{"div7_0",    1'b1, 2'b11, 5'd7,  5'd0,  5'd0,  1'b1, 1};
    v[5]  = '{"add23_1",   1'b0, 2'b00, 5'd23, 5'd1,  5'd0,  1'b1, 1};
    v[6]  = '{"mul22_22",  1'b1, 2'b10, 5'd22, 5'd22, 5'd1,  1'b0, 4};
    v[8]  = '{"add22_0",   1'b0, 2'b00, 5'd22, 5'd0,  5'd22, 1'b0, 1};
    v[9]  = '{"sub5_5",    1'b1, 2'b01, 5'd5,  5'd5,  5'd0,  1'b0, 1};
    v[10] = '{"sub0_22",   1'b0, 2'b01, 5'd0,  5'd22, 5'd1,  1'b0, 1};
    v[11] = '{"mul4_31",   1'b1, 2'b10, 5'd4,  5'd31, 5'd0,  1'b1, 1};
    @(negedge clk);
    check("reset_rsp_valid", rsp_valid, 0);
    check("reset_rsp_data", rsp_data, 0);
    check("reset_rsp_err", rsp_err, 0);
    check("reset_rsp_id", rsp_id, 0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("idle_ready0", req0_ready, 0);
    check("idle_ready1", req1_ready, 0);
    @(negedge clk);
    foreach (v[i]) begin
      run_op(v[i].id, v[i].op, v[i].a, v[i].b, rdy, lat, d, e, ri, after);
      check({v[i].name, "_ready"}, rdy, 1);
      check({v[i].name, "_lat"}, lat, v[i].lat);
      check({v[i].name, "_data"}, d, v[i].data);
      check({v[i].name, "_err"}, e, v[i].err);
      check({v[i].name, "_id"}, ri, v[i].id);
      check({v[i].name, "_release"}, after, 0);
    end
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    drive(1'b0, 2'b00, 5'd1, 5'd2);
    drive(1'b1, 2'b00, 5'd3, 5'd4);
    rsp_ready = 1'b1;
    both = 1'b0;
    for (int c = 0; c < 40 && g.size() < 4; c++) begin
      #1;
      if (req0_ready && req1_ready) both = 1'b1;
      if (req0_ready) begin
        g.push_back(0);
        t.push_back(c);
      end else if (req1_ready) begin
        g.push_back(1);
        t.push_back(c);
      end
      if (g.size() < 4) @(negedge clk);
    end
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    check("rr_grants", g.size(), 4);
    check("rr_exclusive", both, 0);
    for (int i = 0; i < g.size(); i++) check("rr_order", g[i], i % 2);
    for (int i = 0; i + 1 < t.size(); i++) check("rr_spacing", t[i+1] - t[i], 3);
    @(negedge clk);
    @(negedge clk);
    rsp_ready = 1'b0;
    drive(1'b1, 2'b00, 5'd2, 5'd3);
    @(posedge clk);
    @(negedge clk);
    req1_valid = 1'b0;
    lat = 0;
    while (!rsp_valid && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    check("stall_lat", lat, 1);
    d0 = rsp_data;
    e0 = rsp_err;
    i0 = rsp_id;
    check("stall_data", d0, 5);
    drive(1'b0, 2'b00, 5'd4, 5'd4);
    drive(1'b1, 2'b00, 5'd4, 5'd4);
    stable = 1'b1;
    rdy_low = 1'b1;
    for (int c = 0; c < 10; c++) begin
      #1;
      if (!rsp_valid || rsp_data !== d0 || rsp_err !== e0 || rsp_id !== i0) stable = 1'b0;
      if (req0_ready || req1_ready) rdy_low = 1'b0;
      @(negedge clk);
    end
    req1_valid = 1'b0;
    check("stall_stable", stable, 1);
    check("stall_ready_low", rdy_low, 1);
    rsp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rsp_ready = 1'b0;
    #1;
    check("stall_release_valid", rsp_valid, 0);
    check("stall_release_idle", req0_ready, 1);
    req0_valid = 1'b0;
    @(negedge clk);
    drive(1'b0, 2'b10, 5'd7, 5'd5);
    @(posedge clk);
    @(negedge clk);
    req0_valid = 1'b0;
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("rst_rsp_valid", rsp_valid, 0);
    check("rst_rsp_data", rsp_data, 0);
    @(negedge clk);
    rst_n = 1'b1;
    after = 1'b0;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      if (rsp_valid) after = 1'b1;
    end
    check("rst_dropped", after, 0);
    run_op(1'b0, 2'b00, 5'd1, 5'd1, rdy, lat, d, e, ri, after);
    check("post_rst_ready", rdy, 1);
    check("post_rst_lat", lat, 1);
    check("post_rst_data", d, 2);
    check("post_rst_err", e, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
